// File: rtl/fefet_wv_ctrl_if.sv
// rtl/fefet_wv_ctrl_if.sv - request/response, array drive and sense signals of the write-verify sequencer
interface fefet_wv_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int LVL_W  = 4,
    parameter int AMP_W  = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_op;
    logic [LVL_W-1:0]  req_target;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [4:0]        rsp_pulses;
    logic [ADDR_W-1:0] arr_addr;
    logic              arr_gate_en;
    logic              arr_gate_pol;
    logic [AMP_W-1:0]  arr_gate_amp;
    logic              arr_read_en;
    logic [LVL_W-1:0]  sense_code;
    logic              sense_valid;

    modport master (
        output req_valid, req_addr, req_op, req_target, rsp_ready, sense_code, sense_valid,
        input  req_ready, rsp_valid, rsp_status, rsp_pulses,
               arr_addr, arr_gate_en, arr_gate_pol, arr_gate_amp, arr_read_en
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_target, rsp_ready, sense_code, sense_valid,
        output req_ready, rsp_valid, rsp_status, rsp_pulses,
               arr_addr, arr_gate_en, arr_gate_pol, arr_gate_amp, arr_read_en
    );
endinterface

// File: rtl/fefet_wv_ctrl.sv
// rtl/fefet_wv_ctrl.sv - FeFET write-verify sequencer: ISPP gate pulses with read-back after each pulse
module fefet_wv_ctrl #(
    parameter int ADDR_W       = 6,
    parameter int LVL_W        = 4,
    parameter int AMP_W        = 6,
    parameter int PULSE_CYC    = 8,
    parameter int SETTLE_CYC   = 4,
    parameter int READ_TIMEOUT = 16,
    parameter int MAX_PULSES   = 15,
    parameter int AMP_START    = 16,
    parameter int AMP_STEP     = 2,
    parameter int AMP_MAX      = 63
) (
    input  logic            clk,
    input  logic            rst,
    fefet_wv_ctrl_if.slave  bus
);
    localparam int CMAX_A = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CMAX   = (CMAX_A > READ_TIMEOUT) ? CMAX_A : READ_TIMEOUT;
    localparam int CNT_W  = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, PULSE, SETTLE, READ, CHECK, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_q;
    logic [LVL_W-1:0]  target_q;
    logic [LVL_W-1:0]  code_q;
    logic [AMP_W-1:0]  amp;
    logic [4:0]        pulses;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [1:0]        rsp_status_q;
    logic [4:0]        rsp_pulses_q;
    logic [ADDR_W-1:0] arr_addr_q;
    logic              gate_en_q;
    logic              gate_pol_q;
    logic [AMP_W-1:0]  gate_amp_q;
    logic              read_en_q;

    logic [AMP_W:0]    amp_sum;
    logic [AMP_W-1:0]  amp_next;
    logic              pass;

    // Step is summed one bit wider so a carry past the DAC range still clamps to AMP_MAX.
    always_comb begin
        amp_sum  = {1'b0, amp} + (AMP_W+1)'(AMP_STEP);
        amp_next = (amp_sum > (AMP_W+1)'(AMP_MAX)) ? AMP_W'(AMP_MAX) : amp_sum[AMP_W-1:0];
        pass     = op_q ? (code_q <= target_q) : (code_q >= target_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= 1'b0;
            target_q     <= '0;
            code_q       <= '0;
            amp          <= '0;
            pulses       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'b00;
            rsp_pulses_q <= '0;
            arr_addr_q   <= '0;
            gate_en_q    <= 1'b0;
            gate_pol_q   <= 1'b0;
            gate_amp_q   <= '0;
            read_en_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        target_q    <= bus.req_target;
                        arr_addr_q  <= bus.req_addr;
                        amp         <= AMP_W'(AMP_START);
                        pulses      <= 5'd1;
                        cnt         <= '0;
                        req_ready_q <= 1'b0;
                        gate_en_q   <= 1'b1;
                        gate_pol_q  <= ~bus.req_op;
                        gate_amp_q  <= AMP_W'(AMP_START);
                        state       <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == CNT_W'(PULSE_CYC - 1)) begin
                        cnt        <= '0;
                        gate_en_q  <= 1'b0;
                        gate_pol_q <= 1'b0;
                        gate_amp_q <= '0;
                        state      <= SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt       <= '0;
                        read_en_q <= 1'b1;
                        state     <= READ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (bus.sense_valid) begin
                        code_q    <= bus.sense_code;
                        read_en_q <= 1'b0;
                        state     <= CHECK;
                    end else if (cnt == CNT_W'(READ_TIMEOUT - 1)) begin
                        read_en_q    <= 1'b0;
                        rsp_status_q <= 2'b10;
                        rsp_pulses_q <= pulses;
                        rsp_valid_q  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (pass || pulses == 5'(MAX_PULSES)) begin
                        rsp_status_q <= pass ? 2'b00 : 2'b01;
                        rsp_pulses_q <= pulses;
                        rsp_valid_q  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        amp        <= amp_next;
                        pulses     <= pulses + 5'd1;
                        cnt        <= '0;
                        gate_en_q  <= 1'b1;
                        gate_pol_q <= ~op_q;
                        gate_amp_q <= amp_next;
                        state      <= PULSE;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_status   = rsp_status_q;
    assign bus.rsp_pulses   = rsp_pulses_q;
    assign bus.arr_addr     = arr_addr_q;
    assign bus.arr_gate_en  = gate_en_q;
    assign bus.arr_gate_pol = gate_pol_q;
    assign bus.arr_gate_amp = gate_amp_q;
    assign bus.arr_read_en  = read_en_q;
endmodule
